ex_gcd_gcd_unit_arb: RTL and testbench

Round-robin arbiter that shares a single GCD unit among `p_nreqs` requesters. Each requester has its own val/rdy request and response ports. The arbiter forwards one granted request to the GCD unit and routes the unit's response back to the requester that issued it. It sits between the requester-side sources/sinks and one `ex_gcd_GcdUnit` instance, and allows at most one transaction in flight.

---
 rtl/ex_gcd_gcd_unit_arb_pkg.sv | 17 +
 rtl/ex_gcd_gcd_unit_arb_chk.sv | 31 +++
 rtl/ex_gcd_rr_arb_en.sv | 62 ++++++
 rtl/ex_gcd_gcd_unit_arb.sv | 145 ++++++++++++++
 tb/tb_ex_gcd_gcd_unit_arb.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_gcd_gcd_unit_arb_pkg.sv
// ex_gcd_gcd_unit_arb_pkg
// Shared GCD message types and widths used by the GCD unit arbiter.
//   ex_gcd_req_msg_t  : {a[15:0], b[15:0]} operand pair sent to the GCD unit
//   ex_gcd_resp_msg_t : 16-bit GCD result returned by the unit
package ex_gcd_gcd_unit_arb_pkg;

    localparam int EX_GCD_REQ_MSG_NBITS  = 32;
    localparam int EX_GCD_RESP_MSG_NBITS = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } ex_gcd_req_msg_t;

    typedef logic [EX_GCD_RESP_MSG_NBITS-1:0] ex_gcd_resp_msg_t;

endpackage

// File: rtl/ex_gcd_gcd_unit_arb_chk.sv
// ex_gcd_gcd_unit_arb_chk
// Protocol checks for the GCD unit arbiter, active outside reset.
//   clk, reset   : clock and reset of the arbiter
//   is_idle      : arbiter has no transaction outstanding
//   in_req_rdy   : per-requester request ready (must be at most one-hot)
//   in_resp_val  : per-requester response valid
//   gcd_req_val, gcd_resp_rdy, gcd_resp_val : GCD-side handshake signals
module ex_gcd_gcd_unit_arb_chk #(
    parameter int p_nreqs = 2
) (
    input logic               clk,
    input logic               reset,
    input logic               is_idle,
    input logic [p_nreqs-1:0] in_req_rdy,
    input logic [p_nreqs-1:0] in_resp_val,
    input logic               gcd_req_val,
    input logic               gcd_resp_rdy,
    input logic               gcd_resp_val
);

    a_outputs_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({in_req_rdy, in_resp_val, gcd_req_val, gcd_resp_rdy}));

    a_req_rdy_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(in_req_rdy));

    // A response with nothing outstanding means the GCD unit broke protocol.
    a_no_resp_in_idle: assert property (@(posedge clk) disable iff (reset)
        !(is_idle && gcd_resp_val));

endmodule

// File: rtl/ex_gcd_rr_arb_en.sv
// ex_gcd_rr_arb_en
// Round-robin arbiter with a one-hot priority pointer that only advances when
// the caller says the grant was actually used.
//   clk, reset : clock, synchronous active-high reset
//   en         : grant consumed this cycle; advance priority past the winner
//   reqs       : per-requester request bits
//   grants     : one-hot grant (zero when no request)
module ex_gcd_rr_arb_en #(
    parameter int p_nreqs = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nreqs-1:0] reqs,
    output logic [p_nreqs-1:0] grants
);

    logic [p_nreqs-1:0] prio_reg;
    logic [p_nreqs-1:0] grants_s;
    logic [p_nreqs-1:0] prio_next_s;
    logic               found_s;

    // Circular search for the first request at or after the priority pointer.
    // The outer loop picks the (single) set prio bit so all indices stay constant.
    always_comb begin
        grants_s = '0;
        found_s  = 1'b0;
        for (int s = 0; s < p_nreqs; s++) begin
            if (prio_reg[s]) begin
                for (int k = 0; k < p_nreqs; k++) begin
                    if (!found_s && reqs[(s + k) % p_nreqs]) begin
                        grants_s[(s + k) % p_nreqs] = 1'b1;
                        found_s = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner rotated left by one, wrapping from the top requester to requester 0.
    always_comb begin
        prio_next_s = {grants_s[p_nreqs-2:0], grants_s[p_nreqs-1]};
    end

    // Priority pointer: requester 0 first after reset, moves only on a used grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_reg <= {{(p_nreqs-1){1'b0}}, 1'b1};
        end else if (en && (|grants_s)) begin
            prio_reg <= prio_next_s;
        end else begin
            prio_reg <= prio_reg;
        end
    end

    assign grants = grants_s;

endmodule

// File: rtl/ex_gcd_gcd_unit_arb.sv
// ex_gcd_gcd_unit_arb
// Shares one GCD unit among p_nreqs requesters, one transaction in flight.
// Request and response paths are combinational pass-through gated by state.
//   clk, reset                           : clock, synchronous active-high reset
//   in_req_val/rdy/msg  [p_nreqs]        : requester request ports ({a,b} per slot)
//   in_resp_val/rdy/msg [p_nreqs]        : requester response ports (msg broadcast)
//   gcd_req_val/rdy/msg                  : request port to the GCD unit
//   gcd_resp_val/rdy/msg                 : response port from the GCD unit
module ex_gcd_gcd_unit_arb
    import ex_gcd_gcd_unit_arb_pkg::*;
#(
    parameter int p_nreqs = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [p_nreqs-1:0]                       in_req_val,
    output logic [p_nreqs-1:0]                       in_req_rdy,
    input  logic [p_nreqs*EX_GCD_REQ_MSG_NBITS-1:0]  in_req_msg,
    output logic [p_nreqs-1:0]                       in_resp_val,
    input  logic [p_nreqs-1:0]                       in_resp_rdy,
    output logic [p_nreqs*EX_GCD_RESP_MSG_NBITS-1:0] in_resp_msg,
    output logic                                     gcd_req_val,
    input  logic                                     gcd_req_rdy,
    output logic [EX_GCD_REQ_MSG_NBITS-1:0]          gcd_req_msg,
    input  logic                                     gcd_resp_val,
    output logic                                     gcd_resp_rdy,
    input  logic [EX_GCD_RESP_MSG_NBITS-1:0]         gcd_resp_msg
);

    localparam int OWNER_W = $clog2(p_nreqs);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

    logic [0:0]         state_reg;
    logic [0:0]         state_next;
    logic [OWNER_W-1:0] owner_reg;
    logic [OWNER_W-1:0] grant_idx_s;
    logic [p_nreqs-1:0] grants_s;
    ex_gcd_req_msg_t    grant_msg_s;
    logic               req_go_s;
    logic               resp_go_s;

    ex_gcd_rr_arb_en #(
        .p_nreqs (p_nreqs)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (req_go_s),
        .reqs   (in_req_val),
        .grants (grants_s)
    );

    // Encode the one-hot grant and pick the granted requester's message.
    always_comb begin
        grant_idx_s = '0;
        grant_msg_s = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            if (grants_s[i]) begin
                grant_idx_s = OWNER_W'(i);
                grant_msg_s = in_req_msg[EX_GCD_REQ_MSG_NBITS*i +: EX_GCD_REQ_MSG_NBITS];
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Handshake steering; everything is forced low while reset is held so the
    // outputs are quiet even before the first reset edge settles the state.
    always_comb begin
        in_req_rdy   = '0;
        in_resp_val  = '0;
        gcd_req_val  = 1'b0;
        gcd_req_msg  = '0;
        gcd_resp_rdy = 1'b0;
        if (reset) begin
            gcd_req_val = 1'b0;
        end else if (state_reg == STATE_IDLE) begin
            gcd_req_val = |in_req_val;
            gcd_req_msg = grant_msg_s;
            in_req_rdy  = grants_s & {p_nreqs{gcd_req_rdy}};
        end else begin
            in_resp_val[owner_reg] = gcd_resp_val;
            gcd_resp_rdy           = in_resp_rdy[owner_reg];
        end
    end

    // Result is broadcast; only the owner sees a matching val.
    always_comb begin
        for (int i = 0; i < p_nreqs; i++) begin
            in_resp_msg[EX_GCD_RESP_MSG_NBITS*i +: EX_GCD_RESP_MSG_NBITS] = gcd_resp_msg;
        end
    end

    assign req_go_s  = (state_reg == STATE_IDLE) && gcd_req_val && gcd_req_rdy;
    assign resp_go_s = (state_reg == STATE_BUSY) && gcd_resp_val && gcd_resp_rdy;

    // Next-state logic for the idle/busy transaction FSM.
    always_comb begin
        case (state_reg)
            STATE_IDLE: state_next = req_go_s  ? STATE_BUSY : STATE_IDLE;
            STATE_BUSY: state_next = resp_go_s ? STATE_IDLE : STATE_BUSY;
            default:    state_next = STATE_IDLE;
        endcase
    end

    // State and owner registers; owner is captured on request acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= STATE_IDLE;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= req_go_s ? grant_idx_s : owner_reg;
        end
    end

`ifndef SYNTHESIS
    ex_gcd_gcd_unit_arb_chk #(
        .p_nreqs (p_nreqs)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .is_idle      (state_reg == STATE_IDLE),
        .in_req_rdy   (in_req_rdy),
        .in_resp_val  (in_resp_val),
        .gcd_req_val  (gcd_req_val),
        .gcd_resp_rdy (gcd_resp_rdy),
        .gcd_resp_val (gcd_resp_val)
    );

    // Line trace: "I" or "B<owner>" followed by per-port val/rdy bits.
    function automatic string line_trace();
        string st;
        if (state_reg == STATE_IDLE) begin
            st = "I ";
        end else begin
            st = $sformatf("B%0d", owner_reg);
        end
        return $sformatf("%s req %b/%b resp %b/%b", st, in_req_val, in_req_rdy,
                         in_resp_val, in_resp_rdy);
    endfunction
`endif

endmodule

// File: tb/tb_ex_gcd_gcd_unit_arb.sv
module tb_ex_gcd_gcd_unit_arb;

    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    in_req_val;
    logic [NR-1:0]    in_req_rdy;
    logic [NR*32-1:0] in_req_msg;
    logic [NR-1:0]    in_resp_val;
    logic [NR-1:0]    in_resp_rdy;
    logic [NR*16-1:0] in_resp_msg;
    logic             gcd_req_val;
    logic             gcd_req_rdy;
    logic [31:0]      gcd_req_msg;
    logic             gcd_resp_val;
    logic             gcd_resp_rdy;
    logic [15:0]      gcd_resp_msg;

    always #5 clk = ~clk;

    ex_gcd_gcd_unit_arb #(.p_nreqs(NR)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_req_val   (in_req_val),
        .in_req_rdy   (in_req_rdy),
        .in_req_msg   (in_req_msg),
        .in_resp_val  (in_resp_val),
        .in_resp_rdy  (in_resp_rdy),
        .in_resp_msg  (in_resp_msg),
        .gcd_req_val  (gcd_req_val),
        .gcd_req_rdy  (gcd_req_rdy),
        .gcd_req_msg  (gcd_req_msg),
        .gcd_resp_val (gcd_resp_val),
        .gcd_resp_rdy (gcd_resp_rdy),
        .gcd_resp_msg (gcd_resp_msg)
    );

    // ---------------- behavioural GCD unit (fixed 4-cycle compute) ----------------
    logic        m_busy, m_resp_val;
    logic [15:0] m_resp_msg, m_a, m_b;
    logic [2:0]  m_cnt;

    function automatic logic [15:0] gcd_f(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] a, b, t;
        a = a_in;
        b = b_in;
        for (int n = 0; n < 64; n++) begin
            if (b != 16'd0) begin
                t = b;
                b = a % b;
                a = t;
            end
        end
        return a;
    endfunction

    assign gcd_req_rdy  = !m_busy;
    assign gcd_resp_val = m_resp_val;
    assign gcd_resp_msg = m_resp_msg;

    always @(posedge clk) begin
        if (reset) begin
            m_busy     <= 1'b0;
            m_resp_val <= 1'b0;
            m_resp_msg <= 16'd0;
            m_a        <= 16'd0;
            m_b        <= 16'd0;
            m_cnt      <= 3'd0;
        end else if (!m_busy) begin
            if (gcd_req_val) begin
                m_busy <= 1'b1;
                m_a    <= gcd_req_msg[31:16];
                m_b    <= gcd_req_msg[15:0];
                m_cnt  <= 3'd3;
            end
        end else if (!m_resp_val) begin
            if (m_cnt == 3'd0) begin
                m_resp_val <= 1'b1;
                m_resp_msg <= gcd_f(m_a, m_b);
            end else begin
                m_cnt <= m_cnt - 3'd1;
            end
        end else if (gcd_resp_rdy) begin
            m_resp_val <= 1'b0;
            m_busy     <= 1'b0;
        end
    end

    // ---------------- checking and scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] q0[$], q1[$], q2[$], q3[$];
    int grant_log[$];
    int acc_cyc[NR];
    int resp_cyc[NR];
    int resp_cnt[NR];

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic void push_exp(input int r, input logic [15:0] v);
        case (r)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction

    function automatic int q_size(input int r);
        case (r)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic int pop_exp(input int r);
        case (r)
            0: return int'(q0.pop_front());
            1: return int'(q1.pop_front());
            2: return int'(q2.pop_front());
            default: return int'(q3.pop_front());
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < NR; i++) begin
            resp_cnt[i] = 0;
            resp_cyc[i] = 0;
            acc_cyc[i]  = 0;
        end
    end

    // Response monitor: any val must be expected; each handshake pops one result.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < NR; i++) begin
                if (in_resp_val[i]) begin
                    check_eq($sformatf("resp_expected_r%0d", i), int'(q_size(i) > 0), 1);
                    if (in_resp_rdy[i] && q_size(i) > 0) begin
                        check_eq($sformatf("resp_data_r%0d", i), int'(in_resp_msg[16*i +: 16]), pop_exp(i));
                        resp_cyc[i] <= cyc;
                        resp_cnt[i] <= resp_cnt[i] + 1;
                    end
                end
            end
        end
    end

    task automatic send(input int r, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        push_exp(r, exp);
        in_req_msg[32*r +: 32] = {a, b};
        in_req_val[r] = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_req_rdy[r]) begin
                grant_log.push_back(r);
                acc_cyc[r] = cyc;
                @(posedge clk);
                #1;
                in_req_val[r] = 1'b0;
                return;
            end
        end
        check_eq($sformatf("accept_timeout_r%0d", r), 0, 1);
        in_req_val[r] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && q3.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check_eq("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_req_val = '0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_quiet(input string pfx);
        check_eq({pfx, "_in_req_rdy"}, int'(in_req_rdy), 0);
        check_eq({pfx, "_in_resp_val"}, int'(in_resp_val), 0);
        check_eq({pfx, "_gcd_req_val"}, int'(gcd_req_val), 0);
        check_eq({pfx, "_gcd_resp_rdy"}, int'(gcd_resp_rdy), 0);
        check_eq({pfx, "_gcd_req_msg"}, int'(gcd_req_msg), 0);
    endtask

    initial begin
        int base0, base1;
        reset       = 1'b1;
        in_req_val  = '1;
        in_resp_rdy = '1;
        in_req_msg  = {32'h0003_0009, 32'h0004_0008, 32'h0015_0031, 32'h001B_000F};

        // Reset state with every requester asserting val.
        repeat (2) @(negedge clk);
        check_quiet("rst");
        in_req_val = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single requester.
        send(0, 16'd15, 16'd5, 16'd5);
        drain();
        check_eq("single_grant", grant_log[0], 0);
        check_eq("single_cnt_r1", resp_cnt[1], 0);

        // Simultaneous requests: 0 first, 1 one idle cycle after 0's response.
        do_reset();
        fork
            send(0, 16'd27, 16'd15, 16'd3);
            send(1, 16'd21, 16'd49, 16'd7);
        join
        drain();
        check_eq("simul_n", grant_log.size(), 2);
        check_eq("simul_first", grant_log[0], 0);
        check_eq("simul_second", grant_log[1], 1);
        check_eq("simul_idle_gap", acc_cyc[1] - resp_cyc[0], 1);

        // Fairness: both hold val for 8 transactions.
        do_reset();
        base0 = resp_cnt[0];
        base1 = resp_cnt[1];
        fork
            repeat (4) send(0, 16'd12, 16'd8, 16'd4);
            repeat (4) send(1, 16'd12, 16'd8, 16'd4);
        join
        drain();
        check_eq("fair_n", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) check_eq($sformatf("fair_order_%0d", i), grant_log[i], i % 2);
        end
        check_eq("fair_cnt_r0", resp_cnt[0] - base0, 4);
        check_eq("fair_cnt_r1", resp_cnt[1] - base1, 4);

        // Response backpressure on requester 1 while requester 0 waits.
        do_reset();
        base1 = resp_cnt[1];
        in_resp_rdy[1] = 1'b0;
        send(1, 16'd0, 16'd7, 16'd7);
        fork
            send(0, 16'd15, 16'd5, 16'd5);
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (in_resp_val[1]) break;
                end
                check_eq("bp_val_seen", int'(in_resp_val[1]), 1);
                repeat (5) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_eq("bp_val_held", int'(in_resp_val[1]), 1);
                    check_eq("bp_req_rdy0", int'(in_req_rdy[0]), 0);
                    check_eq("bp_gcd_req_val", int'(gcd_req_val), 0);
                end
                @(posedge clk);
                #1;
                in_resp_rdy[1] = 1'b1;
            end
        join
        drain();
        check_eq("bp_cnt_r1", resp_cnt[1] - base1, 1);
        check_eq("bp_order", grant_log[1], 0);

        // Wrap-around: move priority to requester 3, then 3 and 0 compete.
        do_reset();
        send(2, 16'd12, 16'd8, 16'd4);
        fork
            send(3, 16'd21, 16'd49, 16'd7);
            send(0, 16'd27, 16'd15, 16'd3);
        join
        drain();
        check_eq("wrap_n", grant_log.size(), 3);
        check_eq("wrap_first", grant_log[1], 3);
        check_eq("wrap_second", grant_log[2], 0);

        // Reset mid-transaction.
        do_reset();
        send(0, 16'd15, 16'd5, 16'd5);
        drain();
        send(1, 16'd21, 16'd49, 16'd7);
        reset = 1'b1;
        in_req_val = 4'b0011;
        @(negedge clk);
        check_quiet("rmid_a");
        @(negedge clk);
        check_quiet("rmid_b");
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        grant_log.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        fork
            send(0, 16'd27, 16'd15, 16'd3);
            send(1, 16'd12, 16'd8, 16'd4);
        join
        drain();
        check_eq("rmid_n", grant_log.size(), 2);
        check_eq("rmid_first", grant_log[0], 0);
        check_eq("rmid_second", grant_log[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
